// File: rtl/traffic_sequencer.sv
// traffic_sequencer: two-road intersection phase controller.
// An eight-phase Moore FSM is timed by a prescaled tick and a per-phase dwell
// counter. Lamp drives are decoded from the registered phase only.
// Optional build macro TRAFFIC_SENSOR_SYNC_EN: when defined, sA/sB pass
// through a two-flop synchronizer before use. This adds two cycles of
// sensor latency.

module traffic_sequencer #(
  parameter int TICK_DIV     = 100000000,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 3,
  parameter int RED_TICKS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sA,
  input  logic       sB,
  output logic [2:0] lightA,
  output logic [2:0] lightB,
  output logic [2:0] state,
  output logic       tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);

  localparam logic [7:0] GREEN_RELOAD  = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] YELLOW_RELOAD = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] RED_RELOAD    = 8'(RED_TICKS - 1);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // all red
    S3 = 3'b011,  // all red
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // all red
    S7 = 3'b111   // all red
  } phase_t;

  phase_t        state_q, state_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [CW-1:0] presc_q, presc_d;
  logic          sa_use, sb_use;
  logic          advance_ok;
  phase_t        next_phase;
  logic [7:0]    next_reload;

`ifdef TRAFFIC_SENSOR_SYNC_EN
  // Two-stage synchronizer for the asynchronous car sensors.
  // Bit 1 carries road A and bit 0 carries road B.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;

  // Next-state logic for the synchronizer stages.
  always_comb begin
    sync1_d = {sA, sB};
    sync2_d = sync1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sa_use = sync2_q[1];
  assign sb_use = sync2_q[0];
`else
  assign sa_use = sA;
  assign sb_use = sB;
`endif

  // Prescaler wrap detection. The phase timing advances only in this cycle.
  assign tick = (presc_q == PRESC_LAST);

  // Select the following phase and its dwell reload. A green phase waits for
  // the opposing road's sensor; every other phase moves on unconditionally.
  always_comb begin
    next_phase  = phase_t'(state_q + 3'd1);
    next_reload = RED_RELOAD;
    advance_ok  = 1'b1;
    case (next_phase)
      S0, S4:         next_reload = GREEN_RELOAD;
      S1, S5:         next_reload = YELLOW_RELOAD;
      S2, S3, S6, S7: next_reload = RED_RELOAD;
      default:        next_reload = RED_RELOAD;
    endcase
    case (state_q)
      S0:      advance_ok = sb_use;
      S4:      advance_ok = sa_use;
      default: advance_ok = 1'b1;
    endcase
  end

  // Next-state logic for the prescaler, the dwell counter and the phase.
  // When the dwell count reaches zero and the advance condition is false,
  // the phase is held with the dwell count kept at zero.
  always_comb begin
    presc_d = tick ? '0 : presc_q + CW'(1);
    state_d = state_q;
    dwell_d = dwell_q;
    if (tick) begin
      if (dwell_q != 8'd0) begin
        dwell_d = dwell_q - 8'd1;
      end else if (advance_ok) begin
        state_d = next_phase;
        dwell_d = next_reload;
      end
    end
  end

  // Registers for the phase, the dwell counter and the prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      dwell_q <= GREEN_RELOAD;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      presc_q <= presc_d;
    end
  end

  // Moore lamp decode from the registered phase.
  // At most one road is non-red in any phase.
  always_comb begin
    lightA = LAMP_R;
    lightB = LAMP_R;
    case (state_q)
      S0:      lightA = LAMP_G;
      S1:      lightA = LAMP_Y;
      S4:      lightB = LAMP_G;
      S5:      lightB = LAMP_Y;
      default: begin
        lightA = LAMP_R;
        lightB = LAMP_R;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed testbench for traffic_sequencer.
// Parameters: TICK_DIV=4, GREEN=3, YELLOW=2, RED=1.
// Cycle n means the state observed just after the n-th rising edge that
// follows reset release. "Tick at cycle 4" therefore means tick is high in
// the cycle observed after edge 3.

module tb_traffic_sequencer;

  logic       clk;
  logic       reset;
  logic       sA;
  logic       sB;
  logic [2:0] lightA;
  logic [2:0] lightB;
  logic [2:0] state;
  logic       tick;

  int n_tests;
  int n_fail;
  int cyc;

  traffic_sequencer #(
    .TICK_DIV    (4),
    .GREEN_TICKS (3),
    .YELLOW_TICKS(2),
    .RED_TICKS   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sA    (sA),
    .sB    (sB),
    .lightA(lightA),
    .lightB(lightB),
    .state (state),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_la(input logic [2:0] s);
    case (s)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_lb(input logic [2:0] s);
    case (s)
      3'd4:    return 3'b001;
      3'd5:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Phase expected under continuous demand (sA=sB=1), cycle modulo 56.
  function automatic logic [2:0] exp_phase(input int c);
    int m;
    m = c % 56;
    if (m < 12) return 3'd0;
    if (m < 20) return 3'd1;
    if (m < 24) return 3'd2;
    if (m < 28) return 3'd3;
    if (m < 40) return 3'd4;
    if (m < 48) return 3'd5;
    if (m < 52) return 3'd6;
    return 3'd7;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic a, input logic b);
    reset = 1'b1;
    sA = a;
    sB = b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lightA", 32'(lightA), 32'b001);
    chk("rst_lightB", 32'(lightB), 32'b100);
    chk("rst_tick", 32'(tick), 32'd0);
  endtask

  initial begin
    logic prev_tick;
    logic [2:0] prev_state;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    reset = 1'b1;
    sA = 1'b0;
    sB = 1'b0;

    // 1) No demand: tick every 4 cycles and S0 is held.
    do_reset(1'b0, 1'b0);
    for (int c = 1; c <= 100; c++) begin
      step();
      chk("idle_tick", 32'(tick), 32'((cyc % 4) == 3));
      chk("idle_state", 32'(state), 32'd0);
    end
    $display("[TB] idle hold: 100 cycles checked");

    // 2) Continuous demand: full 56-cycle rotation, checked over two periods.
    do_reset(1'b1, 1'b1);
    for (int c = 1; c <= 112; c++) begin
      step();
      chk("rot_state", 32'(state), 32'(exp_phase(cyc)));
      chk("rot_lightA", 32'(lightA), 32'(exp_la(exp_phase(cyc))));
      chk("rot_lightB", 32'(lightB), 32'(exp_lb(exp_phase(cyc))));
    end
    $display("[TB] rotation: 112 cycles checked");

    // 3) Hold in S0. A one-cycle sB pulse between ticks is ignored.
    //    A sustained sB exits at the tick of cycle 24.
    do_reset(1'b1, 1'b0);
    run_to(17);
    sB = 1'b1;
    step();
    sB = 1'b0;
    run_to(21);
    chk("hold_s0_c21", 32'(state), 32'd0);
    sB = 1'b1;
    run_to(23);
    chk("hold_s0_c23", 32'(state), 32'd0);
    step();
    chk("hold_s1_c24", 32'(state), 32'd1);
    chk("hold_lightA_c24", 32'(lightA), 32'b010);
    $display("[TB] green hold: S1 state=%0d at cycle %0d", state, cyc);

    // 4) Asynchronous reset in S5 takes effect before the next clock edge.
    do_reset(1'b1, 1'b1);
    run_to(42);
    chk("pre_areset_s5", 32'(state), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_lightA", 32'(lightA), 32'b001);
    chk("areset_lightB", 32'(lightB), 32'b100);
    chk("areset_tick", 32'(tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("post_rst_tick", 32'(tick), 32'(c == 3));
    end
    $display("[TB] async reset: state=%0d lights %b/%b", state, lightA, lightB);

    // 5) Sensor latency at the tick of cycle 12.
`ifdef TRAFFIC_SENSOR_SYNC_EN
    do_reset(1'b1, 1'b0);
    run_to(10);
    sB = 1'b1;
    run_to(12);
    chk("sync_late_c12", 32'(state), 32'd0);
    run_to(16);
    chk("sync_late_c16", 32'(state), 32'd1);
    do_reset(1'b1, 1'b0);
    run_to(9);
    sB = 1'b1;
    run_to(12);
    chk("sync_early_c12", 32'(state), 32'd1);
`else
    do_reset(1'b1, 1'b0);
    run_to(11);
    sB = 1'b1;
    chk("raw_c11", 32'(state), 32'd0);
    step();
    chk("raw_c12", 32'(state), 32'd1);
`endif
    $display("[TB] sensor latency: state=%0d at cycle %0d", state, cyc);

    // 6) Random sensors: safety invariant, and the phase changes only after
    //    a tick cycle.
    do_reset(1'b0, 1'b0);
    prev_tick = tick;
    prev_state = state;
    for (int c = 0; c < 20000; c++) begin
      sA = 1'($urandom_range(0, 1));
      sB = 1'($urandom_range(0, 1));
      step();
      chk("safety", 32'((lightA != 3'b100) && (lightB != 3'b100)), 32'd0);
      if (!prev_tick) chk("change_on_tick", 32'(state), 32'(prev_state));
      prev_tick = tick;
      prev_state = state;
    end
    $display("[TB] random: 20000 cycles checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
